// File: rtl/nmi2ahbl_bridge_if.sv
// Bus bundle for the NMI-to-AHB-Lite bridge: NMI request/response side plus
// the AHB-Lite master signals. The "master" modport is the bridge's view
// (it masters AHB); "slave" is the environment's view (initiator + AHB slave).
interface nmi2ahbl_bridge_if;
    // NMI side
    logic        nmi_valid_i;
    logic [31:0] nmi_addr_i;
    logic [31:0] nmi_wdata_i;
    logic [3:0]  nmi_wstrb_i;
    logic [31:0] nmi_rdata_o;
    logic        nmi_ready_o;
    logic        err_o;
    // AHB-Lite side
    logic [31:0] haddr_o;
    logic [1:0]  htrans_o;
    logic        hwrite_o;
    logic [2:0]  hsize_o;
    logic [2:0]  hburst_o;
    logic [3:0]  hprot_o;
    logic        hmastlock_o;
    logic [31:0] hwdata_o;
    logic [31:0] hrdata_i;
    logic        hready_i;
    logic        hresp_i;

    modport master (
        input  nmi_valid_i, nmi_addr_i, nmi_wdata_i, nmi_wstrb_i,
        output nmi_rdata_o, nmi_ready_o, err_o,
        output haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hprot_o,
        output hmastlock_o, hwdata_o,
        input  hrdata_i, hready_i, hresp_i
    );

    modport slave (
        output nmi_valid_i, nmi_addr_i, nmi_wdata_i, nmi_wstrb_i,
        input  nmi_rdata_o, nmi_ready_o, err_o,
        input  haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o, hprot_o,
        input  hmastlock_o, hwdata_o,
        output hrdata_i, hready_i, hresp_i
    );
endinterface

// File: rtl/nmi2ahbl_bridge.sv
// NMI-to-AHB-Lite bridge: one SINGLE transfer at a time, all outputs
// registered. Byte strobes are decoded into hsize/address offset; strobe
// patterns AHB cannot express complete with an error and no bus transfer.
module nmi2ahbl_bridge #(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    nmi2ahbl_bridge_if.master     bus
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] size;
        logic [1:0] off;
    } dec_t;

    // Strobe -> transfer size and low address bits. 0000 is a word read.
    function automatic dec_t decode(input logic [3:0] s);
        dec_t d;
        d.legal = 1'b1;
        d.size  = 3'b010;
        d.off   = 2'd0;
        case (s)
            4'b0000, 4'b1111: ;
            4'b0011: d.size = 3'b001;
            4'b1100: begin d.size = 3'b001; d.off = 2'd2; end
            4'b0001: d.size = 3'b000;
            4'b0010: begin d.size = 3'b000; d.off = 2'd1; end
            4'b0100: begin d.size = 3'b000; d.off = 2'd2; end
            4'b1000: begin d.size = 3'b000; d.off = 2'd3; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t      state_q, state_d;
    logic        illegal_q, illegal_d;   // current request had an unsupported strobe
    logic [31:0] wdata_q, wdata_d;       // latched write data for the data phase
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    dec_t        dec;

    assign dec = decode(bus.nmi_wstrb_i);

    // Next-state and next-output logic; ready/err default low so they pulse.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        wdata_d   = wdata_q;
        haddr_d   = haddr_q;
        htrans_d  = htrans_q;
        hwrite_d  = hwrite_q;
        hsize_d   = hsize_q;
        hwdata_d  = hwdata_q;
        rdata_d   = rdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.nmi_valid_i) begin
                    wdata_d = bus.nmi_wdata_i;
                    if (dec.legal) begin
                        illegal_d = 1'b0;
                        haddr_d   = {bus.nmi_addr_i[31:2], dec.off};
                        hsize_d   = dec.size;
                        hwrite_d  = (bus.nmi_wstrb_i != 4'b0000);
                        htrans_d  = HTRANS_NONSEQ;
                        state_d   = ADDR;
                    end else begin
                        // Skip the bus: DATA completes this at once with an error.
                        illegal_d = 1'b1;
                        state_d   = DATA;
                    end
                end
            end
            ADDR: begin
                if (bus.hready_i) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_q;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (illegal_q) begin
                    ready_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = RESP;
                end else if (bus.hready_i) begin
                    ready_d = 1'b1;
                    if (bus.hresp_i) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else begin
                        rdata_d = hwrite_q ? 32'h0 : bus.hrdata_i;
                    end
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            illegal_q <= 1'b0;
            wdata_q   <= 32'h0;
            haddr_q   <= 32'h0;
            htrans_q  <= HTRANS_IDLE;
            hwrite_q  <= 1'b0;
            hsize_q   <= 3'b010;
            hwdata_q  <= 32'h0;
            rdata_q   <= 32'h0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            wdata_q   <= wdata_d;
            haddr_q   <= haddr_d;
            htrans_q  <= htrans_d;
            hwrite_q  <= hwrite_d;
            hsize_q   <= hsize_d;
            hwdata_q  <= hwdata_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign bus.nmi_rdata_o = rdata_q;
    assign bus.nmi_ready_o = ready_q;
    assign bus.err_o       = err_q;
    assign bus.haddr_o     = haddr_q;
    assign bus.htrans_o    = htrans_q;
    assign bus.hwrite_o    = hwrite_q;
    assign bus.hsize_o     = hsize_q;
    assign bus.hwdata_o    = hwdata_q;
    assign bus.hburst_o    = 3'b000;
    assign bus.hprot_o     = HPROT_VAL;
    assign bus.hmastlock_o = 1'b0;
endmodule

// File: tb/tb_nmi2ahbl_bridge.sv
// Directed bench for nmi2ahbl_bridge. Inputs are driven and outputs sampled
// just after the falling edge, so every check sees settled registered values.
module tb_nmi2ahbl_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    nmi2ahbl_bridge_if bus();

    nmi2ahbl_bridge #(.HPROT_VAL(4'b0011)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Zero-wait transfer; valid accepted at edge N, ready expected in cycle N+3.
    task automatic run_legal(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                             input logic [31:0] wdata, input logic [31:0] hrd,
                             input logic [31:0] exp_haddr, input logic [2:0] exp_size,
                             input logic [31:0] exp_rdata);
        bus.nmi_valid_i = 1'b1;
        bus.nmi_addr_i  = addr;
        bus.nmi_wstrb_i = strb;
        bus.nmi_wdata_i = wdata;
        bus.hready_i    = 1'b1;
        bus.hresp_i     = 1'b0;
        bus.hrdata_i    = hrd;
        tick();
        chk({tag, "_a_htrans"}, bus.htrans_o, 2'b10);
        chk({tag, "_a_haddr"},  bus.haddr_o, exp_haddr);
        chk({tag, "_a_hsize"},  bus.hsize_o, exp_size);
        chk({tag, "_a_hwrite"}, bus.hwrite_o, (strb != 4'b0000));
        chk({tag, "_a_ready"},  bus.nmi_ready_o, 1'b0);
        tick();
        chk({tag, "_d_htrans"}, bus.htrans_o, 2'b00);
        chk({tag, "_d_hwdata"}, bus.hwdata_o, wdata);
        chk({tag, "_d_ready"},  bus.nmi_ready_o, 1'b0);
        tick();
        chk({tag, "_r_ready"},  bus.nmi_ready_o, 1'b1);
        chk({tag, "_r_err"},    bus.err_o, 1'b0);
        chk({tag, "_r_rdata"},  bus.nmi_rdata_o, exp_rdata);
        bus.nmi_valid_i = 1'b0;
        tick();
        chk({tag, "_post_ready"}, bus.nmi_ready_o, 1'b0);
    endtask

    logic [3:0] tbl_strb [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [2:0] tbl_size [7] = '{3'b010, 3'b001, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [1:0] tbl_off  [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

    initial begin
        bus.nmi_valid_i = 1'b0;
        bus.nmi_addr_i  = 32'h0;
        bus.nmi_wdata_i = 32'h0;
        bus.nmi_wstrb_i = 4'h0;
        bus.hrdata_i    = 32'h0;
        bus.hready_i    = 1'b1;
        bus.hresp_i     = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_htrans", bus.htrans_o, 2'b00);
        chk("rst_ready",  bus.nmi_ready_o, 1'b0);
        chk("rst_err",    bus.err_o, 1'b0);
        chk("rst_rdata",  bus.nmi_rdata_o, 32'h0);
        chk("rst_haddr",  bus.haddr_o, 32'h0);
        chk("rst_hwdata", bus.hwdata_o, 32'h0);
        chk("rst_hwrite", bus.hwrite_o, 1'b0);
        chk("rst_hsize",  bus.hsize_o, 3'b010);
        chk("hburst",     bus.hburst_o, 3'b000);
        chk("hprot",      bus.hprot_o, 4'b0011);
        chk("hmastlock",  bus.hmastlock_o, 1'b0);
        rst = 1'b0;
        tick();

        // Zero-wait read
        run_legal("rd0", 32'h1000_0004, 4'b0000, 32'h0, 32'hDEAD_BEEF,
                  32'h1000_0004, 3'b010, 32'hDEAD_BEEF);

        // Illegal strobe: no bus transfer, error two cycles after acceptance
        bus.nmi_valid_i = 1'b1;
        bus.nmi_addr_i  = 32'h4000_0000;
        bus.nmi_wstrb_i = 4'b0110;
        bus.nmi_wdata_i = 32'h1234_5678;
        tick();
        chk("ill_c1_htrans", bus.htrans_o, 2'b00);
        chk("ill_c1_ready",  bus.nmi_ready_o, 1'b0);
        tick();
        chk("ill_c2_htrans", bus.htrans_o, 2'b00);
        chk("ill_c2_ready",  bus.nmi_ready_o, 1'b1);
        chk("ill_c2_err",    bus.err_o, 1'b1);
        chk("ill_c2_rdata",  bus.nmi_rdata_o, 32'h0);
        bus.nmi_valid_i = 1'b0;
        tick();
        chk("ill_c3_ready",  bus.nmi_ready_o, 1'b0);
        chk("ill_c3_err",    bus.err_o, 1'b0);
        chk("ill_c3_htrans", bus.htrans_o, 2'b00);

        // Byte write, lane 2
        run_legal("bw", 32'h2000_0000, 4'b0100, 32'h00AB_0000, 32'hFFFF_FFFF,
                  32'h2000_0002, 3'b000, 32'h0);

        // Strobe decode table
        for (int i = 0; i < 7; i++) begin
            run_legal($sformatf("tbl%0d", i), 32'h3000_0010, tbl_strb[i], 32'hA5A5_5A5A,
                      32'h0, {30'h0C00_0004, tbl_off[i]}, tbl_size[i], 32'h0);
        end

        // Read with 3 data-phase wait states: ready in cycle N+6
        bus.nmi_valid_i = 1'b1;
        bus.nmi_addr_i  = 32'h5000_0008;
        bus.nmi_wstrb_i = 4'b0000;
        bus.hready_i    = 1'b1;
        bus.hrdata_i    = 32'h0;
        tick();                     // N+1: address phase
        chk("ws_a_htrans", bus.htrans_o, 2'b10);
        tick();                     // N+2: data phase begins
        bus.hready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();                 // N+3..N+5
            chk($sformatf("ws_wait%0d_ready", k), bus.nmi_ready_o, 1'b0);
            chk($sformatf("ws_wait%0d_htrans", k), bus.htrans_o, 2'b00);
        end
        bus.hready_i = 1'b1;
        bus.hrdata_i = 32'hCAFE_F00D;
        tick();                     // N+6
        chk("ws_ready", bus.nmi_ready_o, 1'b1);
        chk("ws_rdata", bus.nmi_rdata_o, 32'hCAFE_F00D);
        chk("ws_err",   bus.err_o, 1'b0);
        bus.nmi_valid_i = 1'b0;
        tick();
        chk("ws_post_ready", bus.nmi_ready_o, 1'b0);

        // AHB ERROR response (two-cycle)
        bus.nmi_valid_i = 1'b1;
        bus.nmi_addr_i  = 32'h6000_0000;
        bus.nmi_wstrb_i = 4'b0000;
        bus.hrdata_i    = 32'h1111_2222;
        tick();
        tick();                     // data phase
        bus.hresp_i  = 1'b1;
        bus.hready_i = 1'b0;
        tick();
        chk("er_wait_ready", bus.nmi_ready_o, 1'b0);
        bus.hready_i = 1'b1;
        tick();
        chk("er_ready", bus.nmi_ready_o, 1'b1);
        chk("er_err",   bus.err_o, 1'b1);
        chk("er_rdata", bus.nmi_rdata_o, 32'h0);
        bus.nmi_valid_i = 1'b0;
        bus.hresp_i     = 1'b0;
        tick();
        chk("er_post_ready", bus.nmi_ready_o, 1'b0);
        chk("er_post_err",   bus.err_o, 1'b0);

        // Reset during the data phase
        bus.nmi_valid_i = 1'b1;
        bus.nmi_addr_i  = 32'h7000_0004;
        bus.nmi_wstrb_i = 4'b0000;
        tick();
        tick();                     // data phase, stall it
        bus.hready_i = 1'b0;
        rst = 1'b1;
        bus.nmi_valid_i = 1'b0;
        tick();
        chk("mrst_htrans", bus.htrans_o, 2'b00);
        chk("mrst_ready",  bus.nmi_ready_o, 1'b0);
        chk("mrst_haddr",  bus.haddr_o, 32'h0);
        rst = 1'b0;
        bus.hready_i = 1'b1;
        tick();
        chk("mrst_post_ready",  bus.nmi_ready_o, 1'b0);
        chk("mrst_post_htrans", bus.htrans_o, 2'b00);
        tick();
        chk("mrst_post2_ready", bus.nmi_ready_o, 1'b0);

        run_legal("rd1", 32'h1000_0013, 4'b0000, 32'h0, 32'h0BAD_F00D,
                  32'h1000_0010, 3'b010, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
